iq_power_detector: RTL and testbench
====================================

Name: iq_power_detector

Overview:
- Multi-channel complex (I/Q) average-power detector.
- Accepts time-interleaved I/Q samples tagged with a channel index and accumulates |I|²+|Q|² per channel over a runtime-selectable power-of-two window.
- Emits one averaged power word per channel per window and maintains per-channel hysteretic over-threshold flags.
- Sits after the DDC/channeliser and feeds the AGC and squelch logic.

Parameters:
- DATA_WIDTH, 16: width of each signed I and Q component.
- NUM_CH, 4: number of interleaved channels (1..16).
- CH_W, 4: width of the channel index. Must satisfy 2^CH_W >= NUM_CH.
- MAX_WIN_BITS, 12: largest supported log2 window length.
- PWR_W (derived, = 2*DATA_WIDTH): width of the power and average words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  detector enable; low clears all windows
- win_bits  in  4  log2 window length, runtime
- thresh_hi  in  PWR_W  flag set level
- thresh_lo  in  PWR_W  flag clear level
- s_valid  in  1  input sample valid
- s_ch  in  CH_W  channel of input sample
- s_i  in  DATA_WIDTH  signed in-phase
- s_q  in  DATA_WIDTH  signed quadrature
- avg_valid  out  1  one-cycle strobe, new average
- avg_ch  out  CH_W  channel of avg_power
- avg_power  out  PWR_W  unsigned window average
- over_flags  out  NUM_CH  per-channel over-threshold flags
- ch_err  out  1  sticky: sample with s_ch >= NUM_CH seen

Behaviour:
- Reset (rst_n low, async):
  - All accumulators, sample counters, pipeline registers and outputs go to 0.
  - Reset values: avg_valid=0, avg_ch=0, avg_power=0, over_flags=0, ch_err=0.
  - Reset mid-window discards all partial sums.
- Stage 1 (register): p = I*I + Q*Q, computed as signed squares and an unsigned sum.
  - p fits in PWR_W with no overflow. Maximum is 2^(PWR_W-1), at I=Q=-2^(DATA_WIDTH-1).
  - The stage also registers the channel index and valid.
- Stage 2 (per-channel state): accumulator acc[ch] of PWR_W+MAX_WIN_BITS bits and counter cnt[ch] of MAX_WIN_BITS bits.
  - On a sample that is not the last in its window: acc += p; cnt += 1.
  - On the last sample (cnt == 2^W-1): the average is (acc + p) >> W, where W is the effective window. The last sample is included.
  - That average is registered into avg_power with avg_ch; avg_valid pulses for 1 cycle. Then acc <= 0 and cnt <= 0.
- Latency: avg_valid asserts exactly 2 clk after the s_valid cycle of the window's final sample.
- Throughput: one sample per clock, any channel order. Back-to-back samples of the same channel accumulate with no bubbles; the read-modify-write on acc[ch] completes in a single cycle.
- Effective window: W = min(win_bits, MAX_WIN_BITS). W=0 gives avg = p for every sample.
- Window-length change: W is registered.
  - Any cycle where the new W differs from the registered W clears every acc/cnt; no avg_valid results.
  - Samples present in stage 2 in that cycle are discarded.
  - Averaging restarts with the following sample.
- Input gating:
  - enable low: samples are ignored and acc/cnt are held cleared. over_flags and ch_err are held.
  - s_ch >= NUM_CH: the sample is dropped and ch_err sets. ch_err clears only on reset.
- Threshold hysteresis, evaluated on each avg_valid for avg_ch:
  - avg_power >= thresh_hi sets the flag.
  - avg_power < thresh_lo clears the flag.
  - Otherwise the flag holds.
  - If thresh_lo > thresh_hi, set wins when both conditions apply.
  - over_flags updates in the same cycle that avg_valid is high.
- Output hold: avg_power and avg_ch hold their last values between strobes.

Optional Feature:
- Macro: IQ_POWER_PEAK_HOLD_EN.
- When defined, the block adds:
  - Output peak_power [PWR_W], carrying the maximum stage-1 p within the window (including the final sample).
  - Per-channel peak registers.
- peak_power is valid with avg_valid and avg_ch. Its register resets to 0 at window end and on every window-clear condition.
- When undefined, the port and the registers are absent.

Test Plan:
- NUM_CH=2, win_bits=2, ch0 driven 4 consecutive cycles with I=3, Q=4 -> avg_valid exactly 2 clk after the 4th sample; avg_ch=0; avg_power=25.
- win_bits=1, I=Q=-32768 on ch1 twice -> avg_power=0x8000_0000 with no wrap; with peak hold, peak_power=0x8000_0000.
- Interleave ch0 (I=10, Q=0) and ch1 (I=0, Q=-2) per cycle, win_bits=3 -> ch0 avg=100 then ch1 avg=4, in consecutive cycles.
- thresh_hi=100, thresh_lo=50, ch0 window averages of 120, 80, 40 -> over_flags[0] reads 1, 1, 0.
- Mid-window: change win_bits from 3 to 2 after 5 samples, then send 4 samples of p=9 -> the only strobe that follows is avg=9 after the 4th new sample.
- s_ch=3 with NUM_CH=2 -> sample dropped and ch_err=1. Then assert rst_n low mid-window -> all outputs 0 and no strobe.

Source files
------------

// File: rtl/iq_power_detector.sv
// iq_power_detector: multi-channel I/Q average-power detector.
// Two-stage pipeline: stage 1 registers p = I*I + Q*Q; stage 2 holds the
// per-channel accumulators/counters and emits one window average per channel
// along with hysteretic over-threshold flags.
// Optional feature macro: IQ_POWER_PEAK_HOLD_EN adds a per-window peak output.
//
// Output handshake: avg_valid is a one-cycle strobe with no back-pressure;
// avg_ch/avg_power (and peak_power) are valid in that cycle and hold after it.
module iq_power_detector #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 4,
   parameter int MAX_WIN_BITS = 12,
   localparam int PWR_W       = 2 * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [3:0]            win_bits,
   input  logic [PWR_W-1:0]      thresh_hi,
   input  logic [PWR_W-1:0]      thresh_lo,
   input  logic                  s_valid,
   input  logic [CH_W-1:0]       s_ch,
   input  logic [DATA_WIDTH-1:0] s_i,
   input  logic [DATA_WIDTH-1:0] s_q,
   output logic                  avg_valid,
   output logic [CH_W-1:0]       avg_ch,
   output logic [PWR_W-1:0]      avg_power,
   output logic [NUM_CH-1:0]     over_flags,
`ifdef IQ_POWER_PEAK_HOLD_EN
   output logic [PWR_W-1:0]      peak_power,
`endif
   output logic                  ch_err
);

   localparam int              AW       = PWR_W + MAX_WIN_BITS;
   localparam logic [3:0]      MAX_W4   = 4'(MAX_WIN_BITS);
   localparam logic [CH_W:0]   NUM_CH_X = (CH_W + 1)'(NUM_CH);

   // Stage 1 registers
   logic                   v1_q, v1_d;
   logic [CH_W-1:0]        ch1_q, ch1_d;
   logic [PWR_W-1:0]       p1_q, p1_d;
   logic                   ch_err_q, ch_err_d;

   // Stage 2 state
   logic [3:0]             w_q, w_d;
   logic [AW-1:0]          acc_q [NUM_CH];
   logic [AW-1:0]          acc_d [NUM_CH];
   logic [MAX_WIN_BITS-1:0] cnt_q [NUM_CH];
   logic [MAX_WIN_BITS-1:0] cnt_d [NUM_CH];
   logic                   avg_valid_q, avg_valid_d;
   logic [CH_W-1:0]        avg_ch_q, avg_ch_d;
   logic [PWR_W-1:0]       avg_power_q, avg_power_d;
   logic [NUM_CH-1:0]      flags_q, flags_d;
`ifdef IQ_POWER_PEAK_HOLD_EN
   logic [PWR_W-1:0]       peak_q [NUM_CH];
   logic [PWR_W-1:0]       peak_d [NUM_CH];
   logic [PWR_W-1:0]       peak_power_q, peak_power_d;
   logic [PWR_W-1:0]       pk_c;
`endif

   // Combinational helpers
   logic signed [PWR_W-1:0] i_ext, q_ext, sq_i, sq_q;
   logic                    ch_ok;
   logic [3:0]              w_eff;
   logic                    w_change;
   logic [MAX_WIN_BITS-1:0] last_cnt;
   logic [AW-1:0]           sum_c;
   logic [AW-1:0]           avg_full;

   // Stage 1: square-and-sum, channel range check, sticky channel error
   always_comb begin
      i_ext    = {{DATA_WIDTH{s_i[DATA_WIDTH-1]}}, s_i};
      q_ext    = {{DATA_WIDTH{s_q[DATA_WIDTH-1]}}, s_q};
      sq_i     = i_ext * i_ext;
      sq_q     = q_ext * q_ext;
      // Each square is at most 2^(PWR_W-2), so the unsigned sum cannot wrap.
      p1_d     = $unsigned(sq_i) + $unsigned(sq_q);
      ch_ok    = ({1'b0, s_ch} < NUM_CH_X);
      v1_d     = enable & s_valid & ch_ok;
      ch1_d    = s_ch;
      ch_err_d = ch_err_q | (enable & s_valid & ~ch_ok);
   end

   // Stage 2: per-channel read-modify-write, window end, hysteresis flags
   always_comb begin
      w_eff       = (win_bits > MAX_W4) ? MAX_W4 : win_bits;
      w_change    = (w_eff != w_q);
      w_d         = w_eff;
      // Count value of the final sample in a 2^W window (all-ones in W bits).
      last_cnt    = ~({MAX_WIN_BITS{1'b1}} << w_q);
      sum_c       = '0;
      avg_full    = '0;
      avg_valid_d = 1'b0;
      avg_ch_d    = avg_ch_q;
      avg_power_d = avg_power_q;
      flags_d     = flags_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
`ifdef IQ_POWER_PEAK_HOLD_EN
      peak_d       = peak_q;
      peak_power_d = peak_power_q;
      pk_c         = '0;
`endif
      if (!enable || w_change) begin
         // Window clear: drop all partial sums and any sample in this stage.
         for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = '0;
            cnt_d[c] = '0;
`ifdef IQ_POWER_PEAK_HOLD_EN
            peak_d[c] = '0;
`endif
         end
      end else if (v1_q) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch1_q == CH_W'(c)) begin
               sum_c = acc_q[c] + {{MAX_WIN_BITS{1'b0}}, p1_q};
`ifdef IQ_POWER_PEAK_HOLD_EN
               pk_c = (p1_q > peak_q[c]) ? p1_q : peak_q[c];
`endif
               if (cnt_q[c] == last_cnt) begin
                  avg_full    = sum_c >> w_q;
                  avg_power_d = avg_full[PWR_W-1:0];
                  avg_ch_d    = ch1_q;
                  avg_valid_d = 1'b1;
                  acc_d[c]    = '0;
                  cnt_d[c]    = '0;
`ifdef IQ_POWER_PEAK_HOLD_EN
                  peak_power_d = pk_c;
                  peak_d[c]    = '0;
`endif
               end else begin
                  acc_d[c] = sum_c;
                  cnt_d[c] = cnt_q[c] + 1'b1;
`ifdef IQ_POWER_PEAK_HOLD_EN
                  peak_d[c] = pk_c;
`endif
               end
            end
         end
      end
      // Flags move together with the strobe; the set test has priority.
      if (avg_valid_d) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (avg_ch_d == CH_W'(c)) begin
               if (avg_power_d >= thresh_hi) begin
                  flags_d[c] = 1'b1;
               end else if (avg_power_d < thresh_lo) begin
                  flags_d[c] = 1'b0;
               end
            end
         end
      end
   end

   // State registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         ch1_q       <= '0;
         p1_q        <= '0;
         ch_err_q    <= 1'b0;
         w_q         <= '0;
         avg_valid_q <= 1'b0;
         avg_ch_q    <= '0;
         avg_power_q <= '0;
         flags_q     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= '0;
            cnt_q[c] <= '0;
`ifdef IQ_POWER_PEAK_HOLD_EN
            peak_q[c] <= '0;
`endif
         end
`ifdef IQ_POWER_PEAK_HOLD_EN
         peak_power_q <= '0;
`endif
      end else begin
         v1_q        <= v1_d;
         ch1_q       <= ch1_d;
         p1_q        <= p1_d;
         ch_err_q    <= ch_err_d;
         w_q         <= w_d;
         avg_valid_q <= avg_valid_d;
         avg_ch_q    <= avg_ch_d;
         avg_power_q <= avg_power_d;
         flags_q     <= flags_d;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= acc_d[c];
            cnt_q[c] <= cnt_d[c];
`ifdef IQ_POWER_PEAK_HOLD_EN
            peak_q[c] <= peak_d[c];
`endif
         end
`ifdef IQ_POWER_PEAK_HOLD_EN
         peak_power_q <= peak_power_d;
`endif
      end
   end

   assign avg_valid  = avg_valid_q;
   assign avg_ch     = avg_ch_q;
   assign avg_power  = avg_power_q;
   assign over_flags = flags_q;
   assign ch_err     = ch_err_q;
`ifdef IQ_POWER_PEAK_HOLD_EN
   assign peak_power = peak_power_q;
`endif

endmodule

// File: tb/tb_iq_power_detector.sv
// Testbench for iq_power_detector (NUM_CH=2): directed vectors with
// hand-computed averages; a monitor pops an expected queue on every strobe
// and checks channel, power, flags, peak and the exact strobe cycle.
module tb_iq_power_detector;

   localparam int DW    = 16;
   localparam int NCH   = 2;
   localparam int CHW   = 4;
   localparam int MWB   = 12;
   localparam int PW    = 2 * DW;
   localparam int EXP_W = 32 + CHW + PW + NCH + PW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic [3:0]     win_bits = '0;
   logic [PW-1:0]  thresh_hi = '1;
   logic [PW-1:0]  thresh_lo = '0;
   logic           s_valid = 1'b0;
   logic [CHW-1:0] s_ch = '0;
   logic [DW-1:0]  s_i = '0;
   logic [DW-1:0]  s_q = '0;
   logic           avg_valid;
   logic [CHW-1:0] avg_ch;
   logic [PW-1:0]  avg_power;
   logic [NCH-1:0] over_flags;
   logic           ch_err;
`ifdef IQ_POWER_PEAK_HOLD_EN
   logic [PW-1:0]  peak_power;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int drv_cyc = 0;
   logic [EXP_W-1:0] exp_q[$];

   iq_power_detector #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CHW), .MAX_WIN_BITS(MWB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .win_bits(win_bits),
      .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
      .s_valid(s_valid), .s_ch(s_ch), .s_i(s_i), .s_q(s_q),
      .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_power(avg_power),
      .over_flags(over_flags),
`ifdef IQ_POWER_PEAK_HOLD_EN
      .peak_power(peak_power),
`endif
      .ch_err(ch_err)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drivers: one sample per negedge; idle drops valid
   task automatic send(input logic [CHW-1:0] ch, input int i, input int q);
      @(negedge clk);
      s_valid = 1'b1;
      s_ch    = ch;
      s_i     = DW'(i);
      s_q     = DW'(q);
      drv_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         s_valid = 1'b0;
      end
   endtask

   // Strobe of the last sent sample is due exactly 2 clocks later
   task automatic expect_avg(input logic [CHW-1:0] ch, input logic [PW-1:0] pwr,
                             input logic [NCH-1:0] flags, input logic [PW-1:0] pk);
      exp_q.push_back({32'(drv_cyc + 2), ch, pwr, flags, pk});
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [31:0]    e_cyc;
      logic [CHW-1:0] e_ch;
      logic [PW-1:0]  e_pwr;
      logic [NCH-1:0] e_flags;
      logic [PW-1:0]  e_pk;
      if (rst_n && avg_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {32'd0, avg_power}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            {e_cyc, e_ch, e_pwr, e_flags, e_pk} = exp_q.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(e_cyc));
            chk("avg_ch", 64'(avg_ch), 64'(e_ch));
            chk("avg_power", 64'(avg_power), 64'(e_pwr));
            chk("over_flags", 64'(over_flags), 64'(e_flags));
`ifdef IQ_POWER_PEAK_HOLD_EN
            chk("peak_power", 64'(peak_power), 64'(e_pk));
`endif
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_avg_valid", 64'(avg_valid), 64'd0);
      chk("rst_avg_ch", 64'(avg_ch), 64'd0);
      chk("rst_avg_power", 64'(avg_power), 64'd0);
      chk("rst_over_flags", 64'(over_flags), 64'd0);
      chk("rst_ch_err", 64'(ch_err), 64'd0);
      rst_n = 1'b1;
      enable = 1'b1;
      win_bits = 4'd2;
      idle(3);

      // W=2, ch0 I=3 Q=4 four times -> 25
      for (int k = 0; k < 4; k++) send(0, 3, 4);
      expect_avg(0, 32'd25, 2'b00, 32'd25);
      idle(4);

      // W=1, full-scale negative on ch1 -> 0x8000_0000, no wrap
      win_bits = 4'd1;
      idle(2);
      send(1, -32768, -32768);
      send(1, -32768, -32768);
      expect_avg(1, 32'h8000_0000, 2'b00, 32'h8000_0000);
      idle(4);

      // W=3, interleaved channels -> ch0 100 then ch1 4 on consecutive cycles
      win_bits = 4'd3;
      idle(2);
      for (int k = 0; k < 8; k++) begin
         send(0, 10, 0);
         if (k == 7) expect_avg(0, 32'd100, 2'b00, 32'd100);
         send(1, 0, -2);
         if (k == 7) expect_avg(1, 32'd4, 2'b00, 32'd4);
      end
      idle(4);

      // Hysteresis: hi=100 lo=50, averages 120, 80, 40 -> 1, 1, 0
      thresh_hi = 32'd100;
      thresh_lo = 32'd50;
      win_bits = 4'd1;
      idle(2);
      send(0, 14, 2);
      send(0, 6, 2);
      expect_avg(0, 32'd120, 2'b01, 32'd200);
      send(0, 8, 4);
      send(0, 8, 4);
      expect_avg(0, 32'd80, 2'b01, 32'd80);
      send(0, 6, 2);
      send(0, 6, 2);
      expect_avg(0, 32'd40, 2'b00, 32'd40);
      idle(4);

      // Mid-window change from W=3 to W=2 after 5 samples
      win_bits = 4'd3;
      idle(2);
      for (int k = 0; k < 5; k++) send(0, 10, 0);
      idle(1);
      win_bits = 4'd2;
      idle(1);
      for (int k = 0; k < 4; k++) send(0, 3, 0);
      expect_avg(0, 32'd9, 2'b00, 32'd9);
      idle(4);

      // Enable low: samples ignored, no strobe
      enable = 1'b0;
      for (int k = 0; k < 4; k++) send(0, 3, 4);
      idle(3);
      enable = 1'b1;
      idle(2);

      // Out-of-range channel sets the sticky error
      send(3, 100, 100);
      idle(1);
      chk("ch_err_set", 64'(ch_err), 64'd1);
      idle(2);
      chk("ch_err_sticky", 64'(ch_err), 64'd1);

      // Reset mid-window: outputs clear and partial sums are lost
      for (int k = 0; k < 3; k++) send(0, 3, 4);
      @(negedge clk);
      s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_avg_valid", 64'(avg_valid), 64'd0);
      chk("mid_rst_avg_power", 64'(avg_power), 64'd0);
      chk("mid_rst_avg_ch", 64'(avg_ch), 64'd0);
      chk("mid_rst_ch_err", 64'(ch_err), 64'd0);
      idle(2);
      rst_n = 1'b1;
      idle(3);
      for (int k = 0; k < 4; k++) send(0, 3, 4);
      expect_avg(0, 32'd25, 2'b00, 32'd25);
      idle(2);

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      chk("pending_expectations", 64'(exp_q.size()), 64'd0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
